// File: rtl/me_result_tx.sv
// rtl/me_result_tx.sv - ME266 result serialiser: encodes SAD/MV results, buffers them,
// and emits each as a 14-cycle serial frame followed by GAP idle cycles.
module me_result_tx #(
  parameter int IN_SAD_W   = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP        = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                res_valid,
  output logic                res_ready,
  input  logic [IN_SAD_W-1:0] res_sad,
  input  logic [4:0]          res_x,
  input  logic [4:0]          res_y,
  output logic                sign_sad,
  output logic                sad_out,
  output logic                x_out,
  output logic                y_out,
  output logic                drop_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int EW = 22;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP_S} state_t;
  state_t state;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic          push, pop, gap_done;
  logic [13:0]   sad14;
  logic [EW-1:0] wr_data, head;
  logic [13:0]   sh_sad;
  logic [3:0]    sh_x, sh_y;
  logic [3:0]    k;
  logic [GW-1:0] gap_cnt;

  // Clamp to -7..+8; +8 keeps its 4-bit pattern 1000, which the receiver reads as +8.
  function automatic logic [3:0] enc_mv(input logic [4:0] v);
    logic signed [4:0] s;
    s = v;
    if (s < -5'sd7)
      return 4'b1001;
    else if (s > 5'sd8)
      return 4'b1000;
    else
      return v[3:0];
  endfunction

  function automatic logic mv_bit(input logic [3:0] v, input logic [3:0] idx);
    case (idx)
      4'd1:    return v[2];
      4'd2:    return v[1];
      4'd3:    return v[0];
      4'd4:    return v[3];
      default: return 1'b0;
    endcase
  endfunction

  assign sad14      = (res_sad >= IN_SAD_W'(16383)) ? 14'h3FFF : res_sad[13:0];
  assign wr_data    = {sad14, enc_mv(res_x), enc_mv(res_y)};
  assign head       = mem[rd_ptr];
  assign push       = res_valid && res_ready;
  assign gap_done   = (state == GAP_S) && (gap_cnt == GW'(GAP - 1));
  assign pop        = (count != '0) && ((state == IDLE) || gap_done);
  assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      res_ready <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count     <= count_next;
      res_ready <= (count_next != (AW+1)'(FIFO_DEPTH));
      if (res_valid && !res_ready)
        drop_err <= 1'b1;
    end
  end

  // The last GAP cycle doubles as IDLE so back-to-back frames keep a 14+GAP period.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      gap_cnt  <= '0;
      sh_sad   <= '0;
      sh_x     <= '0;
      sh_y     <= '0;
      sign_sad <= 1'b0;
      sad_out  <= 1'b0;
      x_out    <= 1'b0;
      y_out    <= 1'b0;
    end else begin
      sign_sad <= 1'b0;
      sad_out  <= 1'b0;
      x_out    <= 1'b0;
      y_out    <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            {sh_sad, sh_x, sh_y} <= head;
            k     <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sign_sad <= 1'b1;
          sad_out  <= sh_sad[4'd13 - k];
          x_out    <= mv_bit(sh_x, k);
          y_out    <= mv_bit(sh_y, k);
          if (k == 4'd13) begin
            gap_cnt <= '0;
            state   <= GAP_S;
          end else begin
            k <= k + 4'd1;
          end
        end
        GAP_S: begin
          if (gap_done) begin
            if (pop) begin
              {sh_sad, sh_x, sh_y} <= head;
              k     <= '0;
              state <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_me_result_tx.sv
// tb/tb_me_result_tx.sv - randomized and directed bench for me_result_tx with a
// frame-schedule reference model and a serial receiver that decodes frames.
module tb_me_result_tx;
  localparam int DEPTH = 4;
  localparam int GAPC  = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_sad;
  logic [4:0]  res_x, res_y;
  logic        sign_sad, sad_out, x_out, y_out, drop_err;

  me_result_tx #(.IN_SAD_W(16), .FIFO_DEPTH(DEPTH), .GAP(GAPC)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready),
    .res_sad(res_sad), .res_x(res_x), .res_y(res_y),
    .sign_sad(sign_sad), .sad_out(sad_out), .x_out(x_out), .y_out(y_out),
    .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;
  bit rst_cyc = 0;

  typedef struct { int start; int sad; int x; int y; } fr_t;
  typedef struct { int start; int len; int sad; int x; int y; int xb; int yb; } rx_t;
  fr_t frames[$];
  rx_t rx[$];

  int  occ = 0;
  bit  m_ready = 0, m_drop = 0, have_last = 0;
  int  last_start = 0;
  bit  exp_sign, exp_sad, exp_x, exp_y;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, $signed(got), $signed(exp), edge_n);
    end
  endtask

  function automatic int clamp_mv(input logic [4:0] v);
    int s;
    s = int'($signed(v));
    if (s < -7) s = -7;
    if (s > 8) s = 8;
    return s;
  endfunction

  function automatic bit frame_mv_bit(input int v, input int kk);
    int e;
    e = v & 15;
    case (kk)
      1: return bit'((e >> 2) & 1);
      2: return bit'((e >> 1) & 1);
      3: return bit'(e & 1);
      4: return bit'((e >> 3) & 1);
      default: return 1'b0;
    endcase
  endfunction

  // Reference: each accepted result gets a frame start cycle of
  // max(accept+2, previous start + 14 + GAP); it leaves the buffer one cycle earlier.
  always @(posedge clk) begin
    fr_t f;
    int kk;
    edge_n++;
    rst_cyc = rst;
    if (rst) begin
      frames.delete();
      occ = 0; m_ready = 0; m_drop = 0; have_last = 0;
    end else begin
      if (res_valid && !m_ready) m_drop = 1;
      if (res_valid && m_ready) begin
        f.start = edge_n + 2;
        if (have_last && last_start + 14 + GAPC > f.start) f.start = last_start + 14 + GAPC;
        f.sad = (int'(res_sad) >= 16383) ? 16383 : int'(res_sad);
        f.x = clamp_mv(res_x);
        f.y = clamp_mv(res_y);
        frames.push_back(f);
        last_start = f.start; have_last = 1; occ++;
      end
      foreach (frames[i]) if (frames[i].start == edge_n + 1) occ--;
      m_ready = (occ != DEPTH);
    end
    while (frames.size() > 0 && frames[0].start + 13 < edge_n) void'(frames.pop_front());
    exp_sign = 0; exp_sad = 0; exp_x = 0; exp_y = 0;
    if (frames.size() > 0 && edge_n >= frames[0].start) begin
      kk = edge_n - frames[0].start;
      exp_sign = 1;
      exp_sad = bit'((frames[0].sad >> (13 - kk)) & 1);
      exp_x = frame_mv_bit(frames[0].x, kk);
      exp_y = frame_mv_bit(frames[0].y, kk);
    end
  end

  always @(negedge clk) begin
    if (edge_n > 0) begin
      check("sign_sad", 32'(sign_sad), 32'(exp_sign));
      check("sad_out", 32'(sad_out), 32'(exp_sad));
      check("x_out", 32'(x_out), 32'(exp_x));
      check("y_out", 32'(y_out), 32'(exp_y));
      check("res_ready", 32'(res_ready), 32'(m_ready));
      check("drop_err", 32'(drop_err), 32'(m_drop));
    end
  end

  // Receiver: shifts on every sign_sad cycle, MV rebuilt as {b4,b1,b2,b3}.
  int bitcnt = 0;
  rx_t cur;
  always @(negedge clk) begin
    int v;
    if (rst_cyc) begin
      bitcnt = 0;
    end else if (sign_sad === 1'b1) begin
      if (bitcnt == 0) begin
        cur.start = edge_n; cur.sad = 0; cur.xb = 0; cur.yb = 0;
      end
      cur.sad = (cur.sad << 1) | int'(sad_out);
      if (bitcnt >= 1 && bitcnt <= 4) begin
        cur.xb = ((cur.xb << 1) | int'(x_out)) & 15;
        cur.yb = ((cur.yb << 1) | int'(y_out)) & 15;
      end
      bitcnt++;
    end else if (bitcnt > 0) begin
      cur.len = bitcnt;
      v = ((cur.xb & 1) << 3) | (cur.xb >> 1);
      cur.x = (v > 8) ? v - 16 : v;
      v = ((cur.yb & 1) << 3) | (cur.yb >> 1);
      cur.y = (v > 8) ? v - 16 : v;
      rx.push_back(cur);
      bitcnt = 0;
    end
  end

  task automatic send(input int sad, input int x, input int y, output int acc);
    int w;
    res_valid = 1'b1;
    res_sad = 16'(sad); res_x = 5'(x); res_y = 5'(y);
    w = 0;
    while (res_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (res_ready !== 1'b1) check("ready_timeout", 32'(res_ready), 32'd1);
    acc = edge_n + 1;
    @(negedge clk);
  endtask

  task automatic wait_rx(input int n);
    int w;
    w = 0;
    while (rx.size() < n && w < 4000) begin
      @(negedge clk);
      w++;
    end
    check("rx_count", 32'(rx.size()), 32'(n));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, acc0, st, n;
    rst = 1'b1; res_valid = 1'b0; res_sad = '0; res_x = '0; res_y = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", 32'(res_ready), 32'd0);
    check("reset_sign", 32'(sign_sad), 32'd0);
    check("reset_drop", 32'(drop_err), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("ready_after_reset", 32'(res_ready), 32'd1);

    rx.delete();
    send(1234, -3, 5, acc);
    res_valid = 1'b0;
    wait_rx(1);
    if (rx.size() >= 1) begin
      check("t1_len", 32'(rx[0].len), 32'd14);
      check("t1_sad_bits", 32'(rx[0].sad), 32'b00010011010010);
      check("t1_xbits", 32'(rx[0].xb), 32'b1011);
      check("t1_x", 32'(rx[0].x), -32'sd3);
      check("t1_y", 32'(rx[0].y), 32'd5);
      check("t1_latency", 32'(rx[0].start - acc), 32'd2);
    end

    rx.delete();
    send(0, 8, -7, acc);
    send(0, -8, -7, acc);
    res_valid = 1'b0;
    wait_rx(2);
    if (rx.size() >= 2) begin
      check("t2_xbits", 32'(rx[0].xb), 32'b0001);
      check("t2_x", 32'(rx[0].x), 32'd8);
      check("t2_y", 32'(rx[0].y), -32'sd7);
      check("t2_sad", 32'(rx[0].sad), 32'd0);
      check("t2_xneg8", 32'(rx[1].x), -32'sd7);
    end

    rx.delete();
    send(20000, 0, 0, acc);
    send(16383, 1, -1, acc);
    send(16382, 15, -16, acc);
    res_valid = 1'b0;
    wait_rx(3);
    if (rx.size() >= 3) begin
      check("t3_sad20000", 32'(rx[0].sad), 32'd16383);
      check("t3_sad16383", 32'(rx[1].sad), 32'd16383);
      check("t3_sad16382", 32'(rx[2].sad), 32'd16382);
      check("t3_x15", 32'(rx[2].x), 32'd8);
      check("t3_yneg16", 32'(rx[2].y), -32'sd7);
    end

    rx.delete();
    for (int i = 0; i < 6; i++) send(100 + i, i - 3, 3 - i, acc);
    res_valid = 1'b0;
    wait_rx(6);
    if (rx.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        check("t4_sad", 32'(rx[i].sad), 32'(100 + i));
        check("t4_x", 32'(rx[i].x), 32'(i - 3));
        if (i > 0) check("t4_period", 32'(rx[i].start - rx[i-1].start), 32'd15);
      end
    end
    check("t4_drop_err", 32'(drop_err), 32'd1);

    rx.delete();
    send(500, 1, 2, acc0);
    send(501, 2, 3, acc);
    send(502, 3, 4, acc);
    res_valid = 1'b0;
    st = acc0 + 2;
    n = 0;
    while (edge_n < st + 7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    check("t5_sign_after_rst", 32'(sign_sad), 32'd0);
    check("t5_drop_cleared", 32'(drop_err), 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("t5_no_frames", 32'(rx.size()), 32'd0);
    send(777, -5, 6, acc);
    res_valid = 1'b0;
    wait_rx(1);
    if (rx.size() >= 1) begin
      check("t5_latency", 32'(rx[0].start - acc), 32'd2);
      check("t5_sad", 32'(rx[0].sad), 32'd777);
      check("t5_x", 32'(rx[0].x), -32'sd5);
    end
    repeat (20) @(negedge clk);

    rx.delete();
    send(11, 0, 0, acc);
    send(22, 0, 0, acc);
    res_valid = 1'b0;
    repeat (14) @(negedge clk);
    send(33, 0, 0, acc);
    res_valid = 1'b0;
    check("t6_ready_push_pop", 32'(res_ready), 32'd1);
    wait_rx(3);
    if (rx.size() >= 3) check("t6_third", 32'(rx[2].sad), 32'd33);

    rx.delete();
    for (int i = 0; i < 150; i++) begin
      int sad, gap;
      case ($urandom_range(0, 2))
        0: sad = 16379 + int'($urandom_range(0, 8));
        1: sad = int'($urandom_range(0, 65535));
        default: sad = int'($urandom_range(0, 64));
      endcase
      send(sad, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), acc);
      gap = int'($urandom_range(0, 3)) == 0 ? int'($urandom_range(1, 20)) : 0;
      if (gap > 0) begin
        res_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    res_valid = 1'b0;
    wait_rx(150);
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
